// File: rtl/llc_bus_snoop_responder.sv
// rtl/llc_bus_snoop_responder.sv - bus-side snoop responder modelling the other caches for the LLC
// Queues LLC bus ops, looks up a snoop result per head entry, sequences HITM writebacks, counts ops.
module llc_bus_snoop_responder #(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int WB_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_busop,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_snoop,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              wb_active,
  output logic              hold,
  output logic [31:0]       cnt_reads,
  output logic [31:0]       cnt_writes,
  output logic [31:0]       cnt_inval,
  output logic [31:0]       cnt_rwim,
  output logic [31:0]       cnt_hitm
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (WB_LATENCY > 1) ? $clog2(WB_LATENCY) : 1;

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INVAL = 3'd3;
  localparam logic [2:0] OP_RWIM  = 3'd4;

  localparam logic [1:0] SNP_NOHIT    = 2'd0;
  localparam logic [1:0] SNP_HIT      = 2'd1;
  localparam logic [1:0] SNP_HITM     = 2'd2;
  localparam logic [1:0] SNP_NORESULT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WB, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_mem_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       occ_q, occ_d;
  logic [1:0]        snoop_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [CW-1:0]     wb_cnt_q;
  logic [31:0]       reads_q, writes_q, inval_q, rwim_q, hitm_q;
  logic              push, pop;
  logic [1:0]        head_snoop;
  logic [2:0]        head_op;
  logic [ADDR_W-1:0] head_addr;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Full blocks acceptance even when the head pops this cycle.
  assign req_ready = (occ_q != (PW+1)'(FIFO_DEPTH));
  assign push      = req_valid & req_ready & (req_busop != 3'd0) & (req_busop <= OP_RWIM);
  assign pop       = (state_q == S_RESP) & rsp_ready;
  assign occ_d     = occ_q + (PW+1)'(push) - (PW+1)'(pop);
  assign head_op   = op_mem_q[rd_ptr_q];
  assign head_addr = addr_mem_q[rd_ptr_q];

  always_comb begin
    head_snoop = SNP_NORESULT;
    if (head_op == OP_READ || head_op == OP_RWIM) begin
      case (head_addr[1:0])
        2'b00:   head_snoop = SNP_HIT;
        2'b01:   head_snoop = SNP_HITM;
        default: head_snoop = SNP_NOHIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem_q[wr_ptr_q]   <= req_busop;
      addr_mem_q[wr_ptr_q] <= req_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      snoop_q  <= '0;
      raddr_q  <= '0;
      wb_cnt_q <= '0;
      reads_q  <= '0;
      writes_q <= '0;
      inval_q  <= '0;
      rwim_q   <= '0;
      hitm_q   <= '0;
    end else begin
      occ_q <= occ_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && req_busop == OP_READ)  reads_q  <= sat_inc(reads_q);
      if (push && req_busop == OP_WRITE) writes_q <= sat_inc(writes_q);
      if (push && req_busop == OP_INVAL) inval_q  <= sat_inc(inval_q);
      if (push && req_busop == OP_RWIM)  rwim_q   <= sat_inc(rwim_q);
      if (state_q == S_LOOKUP) begin
        snoop_q  <= head_snoop;
        raddr_q  <= head_addr;
        wb_cnt_q <= CW'(WB_LATENCY - 1);
        if (head_snoop == SNP_HITM) hitm_q <= sat_inc(hitm_q);
      end else if (state_q == S_WB && wb_cnt_q != '0) begin
        wb_cnt_q <= wb_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (occ_q != '0) state_d = S_LOOKUP;
      S_LOOKUP: state_d = (head_snoop == SNP_HITM) ? S_WB : S_RESP;
      S_WB:     if (wb_cnt_q == '0) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = (occ_d != '0) ? S_LOOKUP : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = (state_q == S_RESP);
    wb_active = (state_q == S_WB);
    hold      = (occ_q != '0) | (state_q != S_IDLE);
  end

  assign rsp_snoop  = snoop_q;
  assign rsp_addr   = raddr_q;
  assign cnt_reads  = reads_q;
  assign cnt_writes = writes_q;
  assign cnt_inval  = inval_q;
  assign cnt_rwim   = rwim_q;
  assign cnt_hitm   = hitm_q;

endmodule

// File: tb/tb_llc_bus_snoop_responder.sv
// tb/tb_llc_bus_snoop_responder.sv - self-checking bench for llc_bus_snoop_responder
// Timestamp-based model of the response pipeline plus directed literal checks.
module tb_llc_bus_snoop_responder;

  localparam int DEPTH = 4;
  localparam int WB    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_busop;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_snoop;
  logic [31:0] rsp_addr;
  logic        wb_active;
  logic        hold;
  logic [31:0] cnt_reads, cnt_writes, cnt_inval, cnt_rwim, cnt_hitm;

  always #5 clk = ~clk;

  llc_bus_snoop_responder #(.ADDR_W(32), .FIFO_DEPTH(DEPTH), .WB_LATENCY(WB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_busop(req_busop), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_snoop(rsp_snoop), .rsp_addr(rsp_addr),
    .wb_active(wb_active), .hold(hold),
    .cnt_reads(cnt_reads), .cnt_writes(cnt_writes), .cnt_inval(cnt_inval),
    .cnt_rwim(cnt_rwim), .cnt_hitm(cnt_hitm)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: accepted entries, plus the edge index at which the head entered lookup.
  typedef struct packed {logic [2:0] op; logic [31:0] addr;} ent_t;
  ent_t        mq[$];
  bit          m_busy;
  int          m_l, m_n;
  logic [31:0] m_reads, m_writes, m_inval, m_rwim, m_hitm;

  function automatic logic [1:0] snoop_of(input ent_t e);
    if (e.op == 3'd1 || e.op == 3'd4) begin
      if (e.addr[1:0] == 2'b00) return 2'd1;
      if (e.addr[1:0] == 2'b01) return 2'd2;
      return 2'd0;
    end
    return 2'd3;
  endfunction

  function automatic bit m_head_hitm();
    return m_busy && mq.size() > 0 && snoop_of(mq[0]) == 2'd2;
  endfunction

  function automatic bit m_valid();
    return m_busy && m_n >= m_l + 1 + (m_head_hitm() ? WB : 0);
  endfunction

  function automatic bit m_wb();
    return m_head_hitm() && m_n >= m_l + 1 && m_n <= m_l + WB;
  endfunction

  function automatic logic [31:0] inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_busy = 0; m_l = 0; m_n = 0;
        m_reads = 0; m_writes = 0; m_inval = 0; m_rwim = 0; m_hitm = 0;
      end else begin
        int e, szb;
        bit pop, push;
        e    = m_n + 1;
        szb  = mq.size();
        pop  = m_valid() && rsp_ready;
        push = req_valid && szb < DEPTH && req_busop >= 3'd1 && req_busop <= 3'd4;
        if (m_head_hitm() && e == m_l + 1) m_hitm = inc(m_hitm);
        if (pop) begin
          void'(mq.pop_front());
          m_busy = 0;
        end
        if (push) begin
          mq.push_back('{op: req_busop, addr: req_addr});
          case (req_busop)
            3'd1:    m_reads  = inc(m_reads);
            3'd2:    m_writes = inc(m_writes);
            3'd3:    m_inval  = inc(m_inval);
            default: m_rwim   = inc(m_rwim);
          endcase
        end
        if (pop) begin
          if (mq.size() != 0) begin m_busy = 1; m_l = e; end
        end else if (!m_busy && szb != 0) begin
          m_busy = 1; m_l = e;
        end
        m_n = e;
      end
    end
  end

  logic [1:0] seen[$];

  initial begin
    forever begin
      @(negedge clk);
      #1;
      check("rsp_valid", rsp_valid, m_valid());
      check("wb_active", wb_active, m_wb());
      check("hold", hold, (mq.size() != 0) || m_busy);
      check("req_ready", req_ready, mq.size() < DEPTH);
      check("cnt_reads", cnt_reads, m_reads);
      check("cnt_writes", cnt_writes, m_writes);
      check("cnt_inval", cnt_inval, m_inval);
      check("cnt_rwim", cnt_rwim, m_rwim);
      check("cnt_hitm", cnt_hitm, m_hitm);
      if (m_valid()) begin
        check("rsp_snoop", rsp_snoop, snoop_of(mq[0]));
        check("rsp_addr", rsp_addr, mq[0].addr);
      end
      if (rsp_valid && rsp_ready) seen.push_back(rsp_snoop);
    end
  end

  task automatic push_op(input logic [2:0] op, input logic [31:0] a);
    req_valid = 1'b1; req_busop = op; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0; req_busop = 3'd0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic wait_seen(input int n, input int budget);
    for (int i = 0; i < budget && seen.size() < n; i++) @(negedge clk);
  endtask

  logic [1:0] exp4 [3];
  logic [1:0] exp5 [4];

  initial begin
    int wbc, first;
    logic [1:0] snp_first;
    rst_n = 1'b0; req_valid = 1'b0; req_busop = 3'd0; req_addr = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_hold", hold, 0);

    // READ hit: response two edges after acceptance.
    push_op(3'd1, 32'h0000_1000);
    @(negedge clk);
    check("t2_valid_e1", rsp_valid, 0);
    @(negedge clk);
    check("t2_valid_e2", rsp_valid, 1);
    check("t2_snoop", rsp_snoop, 2'd1);
    check("t2_addr", rsp_addr, 32'h0000_1000);
    @(negedge clk);
    check("t2_cnt_reads", cnt_reads, 1);
    check("t2_cnt_hitm", cnt_hitm, 0);

    // RWIM HITM: writeback window then response.
    do_reset();
    push_op(3'd4, 32'h0000_2001);
    wbc = 0; first = -1; snp_first = 2'd0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (wb_active) wbc++;
      if (rsp_valid && first < 0) begin first = k; snp_first = rsp_snoop; end
    end
    check("t3_wb_cycles", wbc, 3);
    check("t3_valid_at", first, 5);
    check("t3_snoop", snp_first, 2'd2);
    check("t3_cnt_rwim", cnt_rwim, 1);
    check("t3_cnt_hitm", cnt_hitm, 1);

    // Reset in the middle of a writeback.
    push_op(3'd4, 32'h0000_3001);
    repeat (3) @(negedge clk);
    check("t1_wb_before", wb_active, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t1_wb", wb_active, 0);
    check("t1_valid", rsp_valid, 0);
    check("t1_hold", hold, 0);
    check("t1_cnt_rwim", cnt_rwim, 0);
    check("t1_cnt_hitm", cnt_hitm, 0);
    check("t1_req_ready", req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back with rsp_ready held high.
    seen.delete();
    exp4[0] = 2'd0; exp4[1] = 2'd3; exp4[2] = 2'd3;
    push_op(3'd1, 32'h0000_0402);
    push_op(3'd2, 32'h0000_0500);
    push_op(3'd3, 32'h0000_0601);
    wait_seen(3, 30);
    check("t4_count", seen.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < seen.size()) check($sformatf("t4_snoop%0d", i), seen[i], exp4[i]);
    repeat (3) @(negedge clk);

    // Backpressure: queue fills at four, fifth request refused.
    do_reset();
    rsp_ready = 1'b0;
    push_op(3'd1, 32'h0000_0100);
    push_op(3'd1, 32'h0000_0102);
    push_op(3'd1, 32'h0000_0104);
    push_op(3'd1, 32'h0000_0108);
    check("t5_req_ready_full", req_ready, 0);
    check("t5_hold", hold, 1);
    push_op(3'd1, 32'h0000_010C);
    check("t5_valid_waiting", rsp_valid, 1);
    seen.delete();
    exp5[0] = 2'd1; exp5[1] = 2'd0; exp5[2] = 2'd1; exp5[3] = 2'd1;
    rsp_ready = 1'b1;
    wait_seen(4, 40);
    repeat (4) @(negedge clk);
    check("t5_count", seen.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < seen.size()) check($sformatf("t5_snoop%0d", i), seen[i], exp5[i]);
    check("t5_cnt_reads", cnt_reads, 4);
    check("t5_hold_after", hold, 0);

    // Illegal bus ops are dropped.
    push_op(3'd0, 32'h0000_2000);
    push_op(3'd6, 32'h0000_2001);
    for (int i = 0; i < 4; i++) begin
      check("t6_hold", hold, 0);
      check("t6_valid", rsp_valid, 0);
      @(negedge clk);
    end
    check("t6_cnt_reads", cnt_reads, 4);
    check("t6_cnt_writes", cnt_writes, 0);
    check("t6_cnt_inval", cnt_inval, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
